// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads one 512-bit block and streams W[0..ROUNDS-1].
// Optional macro SCHED_BACK2BACK_EN lets the next block load on the final-word cycle.

module sha256_rotr #(
  parameter int unsigned AMT = 1
) (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  assign y_o = {x_i[AMT-1:0], x_i[31:AMT]};
endmodule

module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_sched: ROUNDS must lie in 16..64");
  end

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];

  // Sigma functions over the sliding window: s0 reads W[t+1], s1 reads W[t+14].
  logic [31:0] r7, r18, r17, r19;
  logic [31:0] sig0, sig1, w_next;

  sha256_rotr #(.AMT(7))  u_rotr7  (.x_i(win_q[1]),  .y_o(r7));
  sha256_rotr #(.AMT(18)) u_rotr18 (.x_i(win_q[1]),  .y_o(r18));
  sha256_rotr #(.AMT(17)) u_rotr17 (.x_i(win_q[14]), .y_o(r17));
  sha256_rotr #(.AMT(19)) u_rotr19 (.x_i(win_q[14]), .y_o(r19));

  assign sig0   = r7  ^ r18 ^ (win_q[1]  >> 3);
  assign sig1   = r17 ^ r19 ^ (win_q[14] >> 10);
  assign w_next = sig1 + win_q[9] + sig0 + win_q[0];

  logic w_fire, blk_fire, is_last;

  assign is_last = (t_q == LAST_IDX);
  assign w_fire  = (state_q == S_EMIT) && w_ready;

`ifdef SCHED_BACK2BACK_EN
  assign blk_ready = (state_q == S_IDLE) || (w_fire && is_last);
`else
  assign blk_ready = (state_q == S_IDLE);
`endif

  assign blk_fire = blk_valid && blk_ready;

  // Outputs come straight from state, so an async reset clears them immediately.
  assign w_valid = (state_q == S_EMIT);
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_last  = w_valid && is_last;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;

    if (w_fire) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = w_next;
      t_d       = t_q + 6'd1;
      if (is_last) begin
        state_d = S_IDLE;
      end
    end

    // A block load wins over the final-word shift when both land on one edge.
    if (blk_fire) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = blk_data[511 - 32*i -: 32];
      end
      t_d     = '0;
      state_d = S_EMIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      // NOTE: the window is reset too, so an abandoned block leaves no data behind.
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed self-checking bench for sha256_msg_sched (ROUNDS=64), inputs driven and outputs sampled on the falling edge.

module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b1;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  localparam logic [511:0] BLK_ZERO = '0;
  localparam logic [511:0] BLK_M1   = {32'h0, 32'h0000_0001, 448'h0};
  localparam logic [511:0] BLK_ABC  = {32'h6162_6380, 448'h0, 32'h0000_0018};
  localparam logic [511:0] BLK_B    = {32'hDEAD_BEEF, 32'h0000_0001, 384'h0, 32'h1234_5678, 32'h0};

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] d);
    for (int i = 0; i < 16; i++) exp_w[i] = d[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  // Presents a block and returns one time unit after the accepting edge.
  task automatic send_block(input logic [511:0] d);
    int n;
    n = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    while (!blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!blk_ready) begin
      n_fail++;
      $display("FAIL blk_accept_timeout: blk_ready=%b after %0d cycles, expected 1", blk_ready, n);
    end
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  // Walks the emitted words against exp_w; optional stall and mid-block reset.
  task automatic check_words(input int stall_at, input int stall_len, input int rst_at);
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      n_checks++;
      if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 6'(t), exp_w[t], (t == 63)}) begin
        n_fail++;
        $display("FAIL word t=%0d: got valid=%b idx=%0d data=%h last=%b, expected valid=1 idx=%0d data=%h last=%b",
                 t, w_valid, w_idx, w_data, w_last, t, exp_w[t], (t == 63));
      end
      got_w[t] = w_data;
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({w_valid, blk_ready, w_last, w_idx} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 6'd0}) begin
          n_fail++;
          $display("FAIL async_reset: got valid=%b ready=%b last=%b idx=%0d, expected 0 1 0 0",
                   w_valid, blk_ready, w_last, w_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (t == stall_at) begin
        w_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          n_checks++;
          if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 6'(t), exp_w[t], (t == 63)}) begin
            n_fail++;
            $display("FAIL stall_hold t=%0d: got valid=%b idx=%0d data=%h, expected valid=1 idx=%0d data=%h",
                     t, w_valid, w_idx, w_data, t, exp_w[t]);
          end
        end
        w_ready = 1'b1;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({w_valid, blk_ready, w_last} !== 3'b010) begin
      n_fail++;
      $display("FAIL back_to_idle: got valid=%b ready=%b last=%b, expected 0 1 0", w_valid, blk_ready, w_last);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({w_valid, blk_ready, w_last, w_idx} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b ready=%b last=%b idx=%0d, expected 0 1 0 0",
               w_valid, blk_ready, w_last, w_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({w_valid, blk_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b ready=%b, expected 0 1", w_valid, blk_ready);
    end
  endtask

  task automatic test_zero_block();
    build_model(BLK_ZERO);
    send_block(BLK_ZERO);
    check_words(-1, 0, -1);
  endtask

  task automatic test_m1_block();
    build_model(BLK_M1);
    send_block(BLK_M1);
    check_words(-1, 0, -1);
    n_checks++;
    if (got_w[16] !== 32'h0200_4000) begin
      n_fail++;
      $display("FAIL m1_w16: got %h, expected 02004000", got_w[16]);
    end
    n_checks++;
    if (got_w[17] !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL m1_w17: got %h, expected 00000001", got_w[17]);
    end
  endtask

  task automatic test_abc_block();
    logic [31:0] ref_w [4];
    ref_w = '{32'h6162_6380, 32'h000F_0000, 32'h7DA8_6405, 32'h6000_03C6};
    build_model(BLK_ABC);
    send_block(BLK_ABC);
    check_words(-1, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_w[16+i] !== ref_w[i]) begin
        n_fail++;
        $display("FAIL abc_w%0d: got %h, expected %h", 16 + i, got_w[16+i], ref_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    build_model(BLK_ABC);
    send_block(BLK_ABC);
    check_words(20, 5, -1);
  endtask

  task automatic test_reset_mid_emit();
    build_model(BLK_M1);
    send_block(BLK_M1);
    check_words(-1, 0, 30);
    build_model(BLK_B);
    send_block(BLK_B);
    check_words(-1, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    build_model(BLK_ABC);
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = BLK_ABC;
    @(posedge clk);
    #1 blk_data = BLK_B;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      n_checks++;
      if ({w_valid, w_idx, w_data} !== {1'b1, 6'(t), exp_w[t]}) begin
        n_fail++;
        $display("FAIL b2b_word t=%0d: got valid=%b idx=%0d data=%h, expected valid=1 idx=%0d data=%h",
                 t, w_valid, w_idx, w_data, t, exp_w[t]);
      end
`ifdef SCHED_BACK2BACK_EN
      exp_rdy = (t == 63);
`else
      exp_rdy = 1'b0;
`endif
      n_checks++;
      if (blk_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_ready t=%0d: got %b, expected %b", t, blk_ready, exp_rdy);
      end
    end
    build_model(BLK_B);
`ifndef SCHED_BACK2BACK_EN
    @(negedge clk);
    n_checks++;
    if ({w_valid, blk_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_bubble: got valid=%b ready=%b, expected 0 1", w_valid, blk_ready);
    end
`endif
    @(posedge clk);
    #1 blk_valid = 1'b0;
    check_words(-1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_m1_block();
    test_abc_block();
    test_backpressure();
    test_reset_mid_emit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
